// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port: round-robin grant, one
// outstanding transaction, per-transaction timeout with saturating error count.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rq_start_0,
  input  logic        rq_start_1,
  input  logic [31:0] rq_addr_0,
  input  logic [31:0] rq_addr_1,
  input  logic [31:0] rq_wdata_0,
  input  logic [31:0] rq_wdata_1,
  input  logic        rq_we_0,
  input  logic        rq_we_1,
  output logic        rq_done_0,
  output logic        rq_done_1,
  output logic [31:0] rq_rdata_0,
  output logic [31:0] rq_rdata_1,
  output logic        rq_err_0,
  output logic        rq_err_1,
  output logic        mem_start,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant_id,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state_q, state_d;
  logic        mem_start_q, mem_start_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        rq_done_0_q, rq_done_0_d;
  logic        rq_done_1_q, rq_done_1_d;
  logic [31:0] rq_rdata_0_q, rq_rdata_0_d;
  logic [31:0] rq_rdata_1_q, rq_rdata_1_d;
  logic        rq_err_0_q, rq_err_0_d;
  logic        rq_err_1_q, rq_err_1_d;
  logic        busy_q, busy_d;
  logic        grant_id_q, grant_id_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  logic        win;
  logic        finish;
  logic        fin_err;
  logic [31:0] fin_rdata;

  always_comb begin
    state_d      = state_q;
    mem_start_d  = mem_start_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    rq_done_0_d  = 1'b0;
    rq_done_1_d  = 1'b0;
    rq_rdata_0_d = rq_rdata_0_q;
    rq_rdata_1_d = rq_rdata_1_q;
    rq_err_0_d   = rq_err_0_q;
    rq_err_1_d   = rq_err_1_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    err_count_d  = err_count_q;
    tmo_cnt_d    = tmo_cnt_q;
    win          = 1'b0;
    finish       = 1'b0;
    fin_err      = 1'b0;
    fin_rdata    = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (rq_start_0 || rq_start_1) begin
          // Under contention the requester not served last time wins.
          win         = (rq_start_0 && rq_start_1) ? ~last_grant_q : rq_start_1;
          grant_id_d  = win;
          mem_addr_d  = win ? rq_addr_1  : rq_addr_0;
          mem_wdata_d = win ? rq_wdata_1 : rq_wdata_0;
          mem_we_d    = win ? rq_we_1    : rq_we_0;
          mem_start_d = 1'b1;
          tmo_cnt_d   = 8'd0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A completion on the terminal count cycle takes priority over timeout.
        if (mem_done) begin
          finish    = 1'b1;
          fin_rdata = mem_we_q ? 32'd0 : mem_rdata;
        end else if (tmo_cnt_q == TMO_LAST) begin
          finish      = 1'b1;
          fin_err     = 1'b1;
          err_count_d = sat_inc8(err_count_q);
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
        if (finish) begin
          mem_start_d  = 1'b0;
          last_grant_d = grant_id_q;
          state_d      = ST_RESP;
          if (grant_id_q) begin
            rq_done_1_d  = 1'b1;
            rq_rdata_1_d = fin_rdata;
            rq_err_1_d   = fin_err;
          end else begin
            rq_done_0_d  = 1'b1;
            rq_rdata_0_d = fin_rdata;
            rq_err_0_d   = fin_err;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_start_q  <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_we_q     <= 1'b0;
      rq_done_0_q  <= 1'b0;
      rq_done_1_q  <= 1'b0;
      rq_rdata_0_q <= 32'd0;
      rq_rdata_1_q <= 32'd0;
      rq_err_0_q   <= 1'b0;
      rq_err_1_q   <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      err_count_q  <= 8'd0;
      tmo_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      mem_start_q  <= mem_start_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      rq_done_0_q  <= rq_done_0_d;
      rq_done_1_q  <= rq_done_1_d;
      rq_rdata_0_q <= rq_rdata_0_d;
      rq_rdata_1_q <= rq_rdata_1_d;
      rq_err_0_q   <= rq_err_0_d;
      rq_err_1_q   <= rq_err_1_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      err_count_q  <= err_count_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign rq_done_0  = rq_done_0_q;
  assign rq_done_1  = rq_done_1_q;
  assign rq_rdata_0 = rq_rdata_0_q;
  assign rq_rdata_1 = rq_rdata_1_q;
  assign rq_err_0   = rq_err_0_q;
  assign rq_err_1   = rq_err_1_q;
  assign mem_start  = mem_start_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, read, write, contention,
// back-to-back, timeout, terminal-count completion, saturation, reset mid-WAIT.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq_start_0, rq_start_1;
  logic [31:0] rq_addr_0, rq_addr_1, rq_wdata_0, rq_wdata_1;
  logic        rq_we_0, rq_we_1;
  logic        rq_done_0, rq_done_1;
  logic [31:0] rq_rdata_0, rq_rdata_1;
  logic        rq_err_0, rq_err_1;
  logic        mem_start;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        grant_id;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .rq_start_0(rq_start_0), .rq_start_1(rq_start_1),
    .rq_addr_0(rq_addr_0), .rq_addr_1(rq_addr_1),
    .rq_wdata_0(rq_wdata_0), .rq_wdata_1(rq_wdata_1),
    .rq_we_0(rq_we_0), .rq_we_1(rq_we_1),
    .rq_done_0(rq_done_0), .rq_done_1(rq_done_1),
    .rq_rdata_0(rq_rdata_0), .rq_rdata_1(rq_rdata_1),
    .rq_err_0(rq_err_0), .rq_err_1(rq_err_1),
    .mem_start(mem_start), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id), .err_count(err_count)
  );

  // Inputs driven and outputs sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq_start_0 = 0; rq_start_1 = 0;
    rq_addr_0 = 0; rq_addr_1 = 0; rq_wdata_0 = 0; rq_wdata_1 = 0;
    rq_we_0 = 0; rq_we_1 = 0; mem_done = 0; mem_rdata = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (rq_done_0 || rq_done_1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mem_start, mem_we, busy, grant_id, rq_done_0, rq_done_1, rq_err_0, rq_err_1} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000000",
        {mem_start, mem_we, busy, grant_id, rq_done_0, rq_done_1, rq_err_0, rq_err_1});
    end
    total++;
    if ({mem_addr, mem_wdata, rq_rdata_0, rq_rdata_1} !== 128'd0 || err_count !== 8'd0) begin
      bad++; $display("FAIL reset_data addr=%h wdata=%h rd0=%h rd1=%h ec=%0d want all 0",
        mem_addr, mem_wdata, rq_rdata_0, rq_rdata_1, err_count);
    end
  endtask

  task automatic test_single_read();
    rq_start_0 = 1; rq_addr_0 = 32'h100; rq_we_0 = 0;
    tick();
    total++;
    if (mem_start !== 1'b1 || mem_addr !== 32'h100 || busy !== 1'b1 || grant_id !== 1'b0) begin
      bad++; $display("FAIL read_issue start=%b addr=%h busy=%b gid=%b want 1 00000100 1 0",
        mem_start, mem_addr, busy, grant_id);
    end
    rq_addr_0 = 32'h999;
    tick();
    total++;
    if (mem_addr !== 32'h100) begin
      bad++; $display("FAIL read_addr_latched got=%h want=00000100", mem_addr);
    end
    tick();
    mem_done = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_done = 0; mem_rdata = 0; rq_start_0 = 0;
    total++;
    if (rq_done_0 !== 1'b1 || rq_done_1 !== 1'b0 || rq_rdata_0 !== 32'hDEADBEEF || rq_err_0 !== 1'b0 || mem_start !== 1'b0) begin
      bad++; $display("FAIL read_done d0=%b d1=%b rd0=%h err0=%b start=%b want 1 0 deadbeef 0 0",
        rq_done_0, rq_done_1, rq_rdata_0, rq_err_0, mem_start);
    end
    tick();
    total++;
    if (rq_done_0 !== 1'b0 || busy !== 1'b0 || rq_rdata_0 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL read_idle d0=%b busy=%b rd0=%h want 0 0 deadbeef", rq_done_0, busy, rq_rdata_0);
    end
  endtask

  task automatic test_write();
    rq_start_1 = 1; rq_we_1 = 1; rq_wdata_1 = 32'h12345678; rq_addr_1 = 32'h40;
    tick();
    total++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h40 || grant_id !== 1'b1) begin
      bad++; $display("FAIL write_issue we=%b wd=%h addr=%h gid=%b want 1 12345678 00000040 1",
        mem_we, mem_wdata, mem_addr, grant_id);
    end
    mem_done = 1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_done = 0; rq_start_1 = 0; rq_we_1 = 0;
    total++;
    if (rq_done_1 !== 1'b1 || rq_rdata_1 !== 32'd0 || rq_err_1 !== 1'b0 || rq_rdata_0 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL write_done d1=%b rd1=%h err1=%b rd0=%h want 1 00000000 0 deadbeef",
        rq_done_1, rq_rdata_1, rq_err_1, rq_rdata_0);
    end
    tick();
    mem_done = 1; mem_rdata = 32'hAAAA5555;
    tick();
    mem_done = 0;
    total++;
    if (busy !== 1'b0 || rq_done_0 !== 1'b0 || rq_done_1 !== 1'b0 || rq_rdata_1 !== 32'd0) begin
      bad++; $display("FAIL idle_stray_done busy=%b d0=%b d1=%b rd1=%h want 0 0 0 0",
        busy, rq_done_0, rq_done_1, rq_rdata_1);
    end
  endtask

  task automatic test_contention();
    bit [31:0] rd;
    bit exp_g;
    do_reset();
    for (int pair = 0; pair < 2; pair++) begin
      rq_start_0 = 1; rq_start_1 = 1; rq_we_0 = 0; rq_we_1 = 0;
      rq_addr_0 = 32'h10 + pair; rq_addr_1 = 32'h20 + pair;
      for (int k = 0; k < 2; k++) begin
        exp_g = k[0];
        // Wait out the IDLE cycle (if any) until the grant is issued.
        for (int n = 0; n < 3 && !mem_start; n++) tick();
        total++;
        if (grant_id !== exp_g || mem_addr !== (exp_g ? rq_addr_1 : rq_addr_0)) begin
          bad++; $display("FAIL contention_grant pair=%0d k=%0d gid=%b addr=%h want %b %h",
            pair, k, grant_id, mem_addr, exp_g, exp_g ? rq_addr_1 : rq_addr_0);
        end
        rd = 32'hA000 + 32'(pair * 2 + k);
        mem_done = 1; mem_rdata = rd;
        tick();
        mem_done = 0;
        total++;
        if ((exp_g ? rq_done_1 : rq_done_0) !== 1'b1 || (exp_g ? rq_rdata_1 : rq_rdata_0) !== rd) begin
          bad++; $display("FAIL contention_done pair=%0d k=%0d d0=%b d1=%b rd0=%h rd1=%h want rdata %h",
            pair, k, rq_done_0, rq_done_1, rq_rdata_0, rq_rdata_1, rd);
        end
        if (exp_g) rq_start_1 = 0; else rq_start_0 = 0;
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rq_start_0 = 1; rq_start_1 = 1; rq_addr_0 = 32'h300; rq_addr_1 = 32'h400;
    tick();
    mem_done = 1; mem_rdata = 32'h1;
    tick();
    mem_done = 0;
    // Requester 0 keeps its start high: that is a fresh request, but 1 waits.
    tick();
    tick();
    total++;
    if (grant_id !== 1'b1 || mem_addr !== 32'h400 || mem_start !== 1'b1) begin
      bad++; $display("FAIL b2b_grant1 gid=%b addr=%h start=%b want 1 00000400 1", grant_id, mem_addr, mem_start);
    end
    mem_done = 1; mem_rdata = 32'h2;
    tick();
    mem_done = 0; rq_start_1 = 0;
    tick();
    tick();
    total++;
    if (grant_id !== 1'b0 || mem_addr !== 32'h300) begin
      bad++; $display("FAIL b2b_grant0 gid=%b addr=%h want 0 00000300", grant_id, mem_addr);
    end
    mem_done = 1; mem_rdata = 32'h3;
    tick();
    mem_done = 0; rq_start_0 = 0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    rq_start_1 = 1; rq_addr_1 = 32'h80; rq_we_1 = 0;
    tick();
    n = 0;
    while (mem_start && n < 20) begin
      n++;
      tick();
    end
    rq_start_1 = 0;
    total++;
    if (n !== 8) begin
      bad++; $display("FAIL timeout_len got=%0d want=8", n);
    end
    total++;
    if (rq_done_1 !== 1'b1 || rq_err_1 !== 1'b1 || rq_rdata_1 !== 32'd0 || err_count !== 8'd1) begin
      bad++; $display("FAIL timeout_resp d1=%b err1=%b rd1=%h ec=%0d want 1 1 0 1",
        rq_done_1, rq_err_1, rq_rdata_1, err_count);
    end
    tick();
  endtask

  task automatic test_terminal_done();
    bit ok;
    rq_start_0 = 1; rq_addr_0 = 32'h500; rq_we_0 = 0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (mem_start !== 1'b1) begin
      bad++; $display("FAIL terminal_still_wait start=%b want 1", mem_start);
    end
    mem_done = 1; mem_rdata = 32'h55;
    tick();
    mem_done = 0; rq_start_0 = 0;
    total++;
    if (rq_done_0 !== 1'b1 || rq_err_0 !== 1'b0 || rq_rdata_0 !== 32'h55 || err_count !== 8'd1) begin
      bad++; $display("FAIL terminal_done d0=%b err0=%b rd0=%h ec=%0d want 1 0 00000055 1",
        rq_done_0, rq_err_0, rq_rdata_0, err_count);
    end
    tick();
    for (int i = 0; i < 300; i++) begin
      rq_start_0 = 1;
      wait_done(ok);
      rq_start_0 = 0;
      total++;
      if (!ok) begin
        bad++; $display("FAIL sat_loop_no_done iter=%0d", i);
      end
      tick();
    end
    total++;
    if (err_count !== 8'd255) begin
      bad++; $display("FAIL err_count_sat got=%0d want=255", err_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    rq_start_1 = 1; rq_addr_1 = 32'h777; rq_we_1 = 1; rq_wdata_1 = 32'h99;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; rq_start_1 = 0; rq_we_1 = 0;
    total++;
    if (mem_start !== 1'b0 || busy !== 1'b0 || rq_done_1 !== 1'b0) begin
      bad++; $display("FAIL rst_mid_wait start=%b busy=%b d1=%b want 0 0 0", mem_start, busy, rq_done_1);
    end
    mem_done = 1; mem_rdata = 32'hBAD;
    tick();
    mem_done = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rq_done_0 !== 1'b0 || rq_done_1 !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rst_stray_done cyc=%0d d0=%b d1=%b busy=%b want 0 0 0", i, rq_done_0, rq_done_1, busy);
      end
      tick();
    end
    total++;
    if ({mem_addr, mem_wdata, rq_rdata_0, rq_rdata_1} !== 128'd0 || err_count !== 8'd0 ||
        grant_id !== 1'b0 || mem_we !== 1'b0 || rq_err_0 !== 1'b0 || rq_err_1 !== 1'b0) begin
      bad++; $display("FAIL rst_values addr=%h wd=%h rd0=%h rd1=%h ec=%0d gid=%b we=%b want all 0",
        mem_addr, mem_wdata, rq_rdata_0, rq_rdata_1, err_count, grant_id, mem_we);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_terminal_done();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
